// File: rtl/scroll_pkg.sv
// Shared types and width/timing helpers for the word-panel scroll controller.
package scroll_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned step_period(input int unsigned base_div,
                                                input int unsigned levels,
                                                input int unsigned spd);
        return base_div << (levels - 32'd1 - spd);
    endfunction

endpackage

// File: rtl/scroll_ctrl_btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stability counter -> one-cycle press pulse.
module btn_debounce
    import scroll_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned         CNT_W    = width_of(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // The DEBOUNCE_CYCLES-th consecutive disagreeing sample commits the change.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d    = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll controller: run/stop FSM, speed-scaled step timer and wrapping position
// index for the word panel, driven by three debounced buttons.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int unsigned MSG_LEN_MAX     = 16,
    parameter int unsigned BASE_DIV        = 4,
    parameter int unsigned SPEED_LEVELS    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                btn_run,
    input  logic                                btn_dir,
    input  logic                                btn_speed,
    input  logic [width_of(MSG_LEN_MAX):0]      msg_len,
    output logic [width_of(MSG_LEN_MAX)-1:0]    pos,
    output logic                                step,
    output logic                                running,
    output logic                                dir,
    output logic [width_of(SPEED_LEVELS)-1:0]   speed
);

    localparam int unsigned       POS_W     = width_of(MSG_LEN_MAX);
    localparam int unsigned       LEN_W     = POS_W + 1;
    localparam int unsigned       SPD_W     = width_of(SPEED_LEVELS);
    localparam int unsigned       CNT_W     = width_of(step_period(BASE_DIV, SPEED_LEVELS, 32'd0));
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MSG_LEN_MAX);
    localparam logic [SPD_W-1:0]  SPD_LAST  = SPD_W'(SPEED_LEVELS - 32'd1);

    logic run_press, dir_press, speed_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_run), .press_o(run_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_dir), .press_o(dir_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_speed), .press_o(speed_press)
    );

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
    logic [POS_W-1:0] pos_q, pos_d, pos_adv, pos_last;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] len_clamp, len_eff;
    logic             pos_oob;

    always_comb begin
        len_clamp = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
        len_eff   = (len_clamp == '0) ? LEN_W'(1) : len_clamp;
        pos_last  = POS_W'(len_eff - 1'b1);
        pos_oob   = ({1'b0, pos_q} >= len_eff);
        cnt_last  = CNT_W'(step_period(BASE_DIV, SPEED_LEVELS, 32'(speed_q)) - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q ^ dir_press;
        speed_d = speed_q;
        pos_adv = pos_q;

        if (speed_press) begin
            speed_d = (speed_q == SPD_LAST) ? '0 : speed_q + 1'b1;
        end

        if (dir_d) begin
            pos_adv = (pos_q == '0) ? pos_last : pos_q - 1'b1;
        end else begin
            pos_adv = (pos_q == pos_last) ? '0 : pos_q + 1'b1;
        end

        case (state_q)
            STOPPED: begin
                cnt_d = '0;
                if (run_press) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                // Stop beats speed change, which beats a terminal-count step.
                if (run_press) begin
                    state_d = STOPPED;
                    cnt_d   = '0;
                end else if (speed_press) begin
                    cnt_d = '0;
                end else if (cnt_q == cnt_last) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    pos_d  = pos_adv;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        if (pos_oob) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOPPED;
            cnt_q   <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            speed_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
        end
    end

    assign pos     = pos_q;
    assign step    = step_q;
    assign running = (state_q == RUNNING);
    assign dir     = dir_q;
    assign speed   = speed_q;

endmodule
